// File: rtl/register_write_arbiter.sv
// Two-requester register-file write arbiter with alternating priority and a one-cycle registered write port.
// Latency: a transfer in cycle N appears on write_enable/write_address/write_data in cycle N+1.
// Backpressure: the losing or stalled requester holds its request; nothing is queued here. Optional macro REGFILE_ARB_PC_FILTER_EN.
module register_write_arbiter #(
  parameter int num_bits     = 32,
  parameter int address_bits = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    req0_valid,
  input  logic [address_bits-1:0] req0_address,
  input  logic [num_bits-1:0]     req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [address_bits-1:0] req1_address,
  input  logic [num_bits-1:0]     req1_data,
  output logic                    req1_ready,
  output logic                    write_enable,
  output logic [address_bits-1:0] write_address,
  output logic [num_bits-1:0]     write_data,
  input  logic [address_bits-1:0] query_address,
  output logic                    query_hazard,
  output logic                    pc_drop
);

  // 1 = requester 1 won most recently, so requester 0 wins the next contention.
  logic                    last_grant;
  logic                    transfer0;
  logic                    transfer1;
  logic                    transfer;
  logic [address_bits-1:0] sel_address;
  logic [num_bits-1:0]     sel_data;
  logic                    keep_write;

  // Grant decision: depends only on valids, stall, reset and priority, never on payload.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && !stall) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign transfer0 = req0_valid & req0_ready;
  assign transfer1 = req1_valid & req1_ready;
  assign transfer  = transfer0 | transfer1;

  // Payload of whichever requester transfers this cycle.
  always_comb begin
    sel_address = req0_address;
    sel_data    = req0_data;
    if (transfer1) begin
      sel_address = req1_address;
      sel_data    = req1_data;
    end
  end

`ifdef REGFILE_ARB_PC_FILTER_EN
  localparam logic [address_bits-1:0] pc_address = address_bits'(15);
  logic is_pc;
  logic drop_q;

  assign is_pc      = (sel_address == pc_address);
  assign keep_write = ~is_pc;
  assign pc_drop    = drop_q;

  // Flag for one cycle that an accepted program-counter write was swallowed.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= transfer & is_pc;
    end
  end
`else
  assign keep_write = 1'b1;
  assign pc_drop    = 1'b0;
`endif

  // Output stage and priority state; address/data hold when nothing is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      last_grant    <= 1'b1;
    end else begin
      write_enable <= transfer & keep_write;
      if (transfer) begin
        last_grant <= transfer1;
      end
      if (transfer && keep_write) begin
        write_address <= sel_address;
        write_data    <= sel_data;
      end
    end
  end

  // A register is hazardous while a write to it is requested or sitting on the write port.
  assign query_hazard = (write_enable && (write_address == query_address)) ||
                        (req0_valid && (req0_address == query_address)) ||
                        (req1_valid && (req1_address == query_address));

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter: stimulus pushes expected writes, a monitor pops them.
module tb_register_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        req0_valid;
  logic [3:0]  req0_address;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_address;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        write_enable;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic [3:0]  query_address;
  logic        query_hazard;
  logic        pc_drop;

  int checks = 0;
  int errors = 0;

  logic [35:0] expq[$];

  register_write_arbiter #(.num_bits(32), .address_bits(4)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .query_address(query_address), .query_hazard(query_hazard), .pc_drop(pc_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    expq.push_back({a, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every write the register file sees must match the next expected one.
  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", write_address, write_data);
      end else begin
        logic [35:0] e;
        e = expq.pop_front();
        if ({write_address, write_data} !== e) begin
          errors++;
          $display("FAIL write_payload actual=%0h expected=%0h", {write_address, write_data}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0;
    req0_valid = 1'b0; req0_address = '0; req0_data = '0;
    req1_valid = 1'b0; req1_address = '0; req1_data = '0;
    query_address = '0;
    tick();
    tick();

    // Readies held low while reset is high.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset_ready0", req0_ready, 0);
    chk("reset_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_we", write_enable, 0);
    chk("rst_wa", write_address, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_pcdrop", pc_drop, 0);

    // Single write, one-cycle latency, one-cycle strobe.
    req0_valid = 1'b1; req0_address = 4'd3; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    push(4'd3, 32'hDEADBEEF);
    tick();
    req0_valid = 1'b0;
    chk("single_we", write_enable, 1);
    chk("single_wa", write_address, 3);
    tick();
    chk("single_we_off", write_enable, 0);
    chk("single_wa_hold", write_address, 3);

    // Continuous contention from reset alternates 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_address = 4'd1; req0_data = 32'h1111_0001;
    req1_valid = 1'b1; req1_address = 4'd2; req1_data = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ready0", req0_ready, (i % 2 == 0));
      chk("alt_ready1", req1_ready, (i % 2 == 1));
      if (i % 2 == 0) push(4'd1, 32'h1111_0001);
      else            push(4'd2, 32'h2222_0002);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Stall blocks grants; requester 0 wins once it drops.
    req0_valid = 1'b1; req1_valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      tick();
      chk("stall_we", write_enable, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready0", req0_ready, 1);
    chk("unstall_ready1", req1_ready, 0);
    push(4'd1, 32'h1111_0001);
    tick();
    #1;
    chk("unstall2_ready1", req1_ready, 1);
    push(4'd2, 32'h2222_0002);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Hazard tracking for a matching and a non-matching query register.
    for (int q = 7; q >= 6; q--) begin
      query_address = 4'(q);
      req1_valid = 1'b1; req1_address = 4'd7; req1_data = 32'h0000_0077;
      #1;
      chk("haz_req", query_hazard, (q == 7));
      chk("haz_ready1", req1_ready, 1);
      push(4'd7, 32'h0000_0077);
      tick();
      req1_valid = 1'b0;
      #1;
      chk("haz_inflight", query_hazard, (q == 7));
      tick();
      chk("haz_clear", query_hazard, 0);
    end

    // Same destination from both: grant order reaches the register file.
    do_reset();
    req0_valid = 1'b1; req0_address = 4'd9; req0_data = 32'h90;
    req1_valid = 1'b1; req1_address = 4'd9; req1_data = 32'h91;
    #1;
    chk("same_ready0", req0_ready, 1);
    push(4'd9, 32'h90);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("same_ready1", req1_ready, 1);
    push(4'd9, 32'h91);
    tick();
    req1_valid = 1'b0;
    tick();

    // Reset right after a transfer clears the output stage.
    req0_valid = 1'b1; req0_address = 4'd5; req0_data = 32'h55;
    #1;
    chk("rstflight_ready0", req0_ready, 1);
    push(4'd5, 32'h55);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstflight_we", write_enable, 0);
    chk("rstflight_wa", write_address, 0);
    chk("rstflight_wd", write_data, 0);
    chk("rstflight_pcdrop", pc_drop, 0);
    chk("rstflight_ready0", req0_ready, 0);
    reset = 1'b0;
    tick();

    // Program-counter destination.
    req0_valid = 1'b1; req0_address = 4'd15; req0_data = 32'h100;
    #1;
    chk("pc_ready0", req0_ready, 1);
`ifdef REGFILE_ARB_PC_FILTER_EN
    tick();
    req0_valid = 1'b0;
    chk("pc_we", write_enable, 0);
    chk("pc_drop", pc_drop, 1);
    tick();
    chk("pc_drop_off", pc_drop, 0);
`else
    push(4'd15, 32'h100);
    tick();
    req0_valid = 1'b0;
    chk("pc_we", write_enable, 1);
    chk("pc_wa", write_address, 15);
    chk("pc_drop", pc_drop, 0);
    tick();
`endif

    tick();
    tick();
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001 Parameter num_bits, default 32: write data width.
REQ-002 Parameter address_bits, default 4: register address width (16 registers; address 15 = program counter).
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  when high, no new grants issued.
REQ-006 req0_valid  input  1  requester 0 (execute writeback) has a write pending.
REQ-007 req0_address  input  address_bits  requester 0 destination register.
REQ-008 req0_data  input  num_bits  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-010 req1_valid, req1_address, req1_data, req1_ready: same as REQ-006..009 for requester 1 (load writeback).
REQ-011 write_enable  output  1  register file write strobe.
REQ-012 write_address  output  address_bits  register file write address.
REQ-013 write_data  output  num_bits  register file write data.
REQ-014 query_address  input  address_bits  register being checked for a pending write.
REQ-015 query_hazard  output  1  a write to query_address is pending or in flight.
REQ-016 pc_drop  output  1  one-cycle pulse: an accepted PC-targeted write was discarded.

Function
REQ-017 Transfer occurs on a cycle where reqN_valid and reqN_ready are both high.
REQ-018 reqN_ready is combinational from valid, stall and priority state; never depends on reqN_data or reqN_address.
REQ-019 stall high: req0_ready = req1_ready = 0.
REQ-020 Only one valid: that requester granted (stall low).
REQ-021 Both valid: requester not granted most recently (last_grant register) is granted; at most one ready high per cycle.
REQ-022 last_grant updates only on a transfer; holds otherwise.
REQ-023 Latency: transfer in cycle N drives write_enable=1, write_address, write_data in cycle N+1 for exactly one cycle.
REQ-024 No transfer in cycle N: write_enable=0 in N+1; write_address/write_data hold previous values.
REQ-025 Back-to-back transfers permitted every cycle; sustained throughput one write per cycle.
REQ-026 Both requesters target same address: normal arbitration; loser written in a later cycle, register file sees writes in grant order.
REQ-027 Ungranted requester must keep valid, address and data stable until its transfer; arbiter does not store ungranted requests.
REQ-028 query_hazard = (write_enable and write_address == query_address) or (req0_valid and req0_address == query_address) or (req1_valid and req1_address == query_address); combinational.
REQ-029 Data passes unmodified; no width conversion; addresses compared full width.

Reset
REQ-030 While reset high: req0_ready = req1_ready = 0 combinationally.
REQ-031 Cycle after reset: write_enable=0, write_address=0, write_data=0, pc_drop=0, last_grant=1 (requester 0 wins first contention).
REQ-032 Reset during an in-flight write discards it; no write_enable in the cycle after reset.

Configuration
REQ-033 Macro REGFILE_ARB_PC_FILTER_EN defined: transfer with address 15 is accepted (ready asserted), write_enable stays 0 in N+1, pc_drop=1 in N+1 for one cycle; last_grant updates normally; query_hazard excludes such writes on the output stage.
REQ-034 Macro undefined: address 15 writes pass through like any other; pc_drop tied 0.

Verification
REQ-035 Reset, then req0_valid=1 addr=3 data=32'hDEADBEEF alone -> req0_ready=1 same cycle; next cycle write_enable=1, write_address=3, write_data=32'hDEADBEEF; following cycle write_enable=0.
REQ-036 Both valid continuously for 4 cycles from reset (addr 1/2) -> grants 0,1,0,1; write_address sequence 1,2,1,2 one per cycle.
REQ-037 Both valid with stall=1 for 3 cycles -> both ready 0, write_enable 0; stall drops -> requester 0 granted first.
REQ-038 req1_valid addr=7, query_address=7 -> query_hazard=1 through cycle after transfer, 0 thereafter; query_address=6 -> 0 throughout.
REQ-039 req0 transfer addr=5, reset asserted next cycle -> write_enable=0 cycle after reset, all outputs zero.
REQ-040 req0 addr=15 data=32'h100 with REGFILE_ARB_PC_FILTER_EN -> ready=1, next cycle write_enable=0, pc_drop=1; without macro -> write_enable=1, write_address=15, pc_drop=0.
